ubi_feedforward_align: RTL



---
 rtl/ubi_pkg.sv | 27 ++
 rtl/ubi_delay_line.sv | 59 +++++
 rtl/ubi_feedforward_align.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ubi_pkg.sv
// ubi_pkg -- shared definitions for the UBI feed-forward alignment block.
//
// Holds the default geometry of the Skein-1024 datapath (block width,
// Threefish pipeline latency, tag width) and the layout of one delay-line
// stage. With UBI_BYPASS_EN defined, every stage also carries a bypass bit.
//
// ubi_stage_t is the default-geometry form of a stage. Parametrised
// instances build the same layout locally at their own widths.

package ubi_pkg;

  localparam int UBI_WIDTH = 1024;
  localparam int UBI_DEPTH = 82;
  localparam int UBI_TAG_W = 4;

  typedef logic [UBI_TAG_W-1:0] ubi_tag_t;

  typedef struct packed {
    logic                 valid;
`ifdef UBI_BYPASS_EN
    logic                 bypass;
`endif
    ubi_tag_t             tag;
    logic [UBI_WIDTH-1:0] data;
  } ubi_stage_t;

endpackage

// File: rtl/ubi_delay_line.sv
// ubi_delay_line -- DEPTH-stage shift register that carries a valid bit and
// an opaque payload (tag, data and optional bypass flag).
//
// The line advances every cycle and never stalls. Only the valid bits are
// reset and cleared by flush. The payload registers run free, because a
// payload is meaningless once its valid bit is low.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of every valid bit
//   in_valid, in_pay  stage-0 input
//   tap_valid, tap_pay  output of the last stage (DEPTH cycles later)
//
// Build option: none here. UBI_BYPASS_EN only changes PAY_W in the parent.

module ubi_delay_line
  import ubi_pkg::*;
#(
  parameter int DEPTH = UBI_DEPTH,
  parameter int PAY_W = $bits(ubi_stage_t) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [PAY_W-1:0] in_pay,
  output logic             tap_valid,
  output logic [PAY_W-1:0] tap_pay
);

  logic [DEPTH-1:0] vld_p;
  logic [PAY_W-1:0] pay_p [DEPTH];

  // Stage boundary: valid bits, reset and flushable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Stage boundary: payload, no reset
  always_ff @(posedge clk) begin
    pay_p[0] <= in_pay;
    for (int i = 1; i < DEPTH; i++) begin
      pay_p[i] <= pay_p[i-1];
    end
  end

  assign tap_valid = vld_p[DEPTH-1];
  assign tap_pay   = pay_p[DEPTH-1];

endmodule

// File: rtl/ubi_feedforward_align.sv
// ubi_feedforward_align -- delays each Skein message block by the Threefish
// pipeline latency, then applies the UBI feed-forward XOR
// (chaining value = cipher output ^ message) when the cipher output arrives.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  synchronous clear (priority over all inputs)
//   msg_valid/data/tag     message block, same cycle it enters the cipher
//   ff_bypass              (UBI_BYPASS_EN only) skip the XOR for this block
//   tf_valid/data          Threefish output
//   out_valid/data/tag     registered feed-forward result
//   inflight, busy         blocks currently in the delay line, non-zero flag
//   align_err              sticky: tf_valid and delayed valid disagreed
//
// Build option: define UBI_BYPASS_EN to add ff_bypass (Threefish-only mode).
//
// Latency from msg_valid to out_valid is DEPTH+1. After a flush, cipher
// outputs belonging to flushed blocks can still appear for up to DEPTH
// cycles. A guard counter hides these from the alignment check.

module ubi_feedforward_align
  import ubi_pkg::*;
#(
  parameter int WIDTH = UBI_WIDTH,
  parameter int DEPTH = UBI_DEPTH,
  parameter int TAG_W = UBI_TAG_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       msg_valid,
  input  logic [WIDTH-1:0]           msg_data,
  input  logic [TAG_W-1:0]           msg_tag,
`ifdef UBI_BYPASS_EN
  input  logic                       ff_bypass,
`endif
  input  logic                       tf_valid,
  input  logic [WIDTH-1:0]           tf_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic                       busy,
  output logic                       align_err
);

  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
`ifdef UBI_BYPASS_EN
    logic             bypass;
`endif
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } pay_t;

  localparam int PAY_W = $bits(pay_t);

`ifdef UBI_BYPASS_EN
  function automatic logic [WIDTH-1:0] ff_mix(input logic [WIDTH-1:0] cv,
                                               input logic [WIDTH-1:0] msg,
                                               input logic             bypass);
    return bypass ? cv : (cv ^ msg);
  endfunction
`else
  function automatic logic [WIDTH-1:0] ff_mix(input logic [WIDTH-1:0] cv,
                                               input logic [WIDTH-1:0] msg);
    return cv ^ msg;
  endfunction
`endif

  pay_t             in_pay;
  pay_t             tap_pay;
  logic             dvalid;
  logic             accept;
  logic             fire;
  logic             guard_on;
  logic             err_set;
  logic [CNT_W-1:0] guard_cnt;

  // A block offered in the flush cycle is dropped.
  assign accept = msg_valid & ~flush;

  always_comb begin
    in_pay      = '0;
    in_pay.tag  = msg_tag;
    in_pay.data = msg_data;
`ifdef UBI_BYPASS_EN
    in_pay.bypass = ff_bypass;
`endif
  end

  ubi_delay_line #(
    .DEPTH (DEPTH),
    .PAY_W (PAY_W)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (accept),
    .in_pay    (in_pay),
    .tap_valid (dvalid),
    .tap_pay   (tap_pay)
  );

  assign fire     = tf_valid & dvalid & ~flush;
  assign guard_on = (guard_cnt != '0);
  // A cipher output with no block at the tap is stale while the guard runs.
  // A block at the tap with no cipher output is always an error.
  assign err_set  = (tf_valid != dvalid) && !(guard_on && tf_valid && !dvalid);

  // Stage boundary: feed-forward output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= fire;
      if (fire) begin
`ifdef UBI_BYPASS_EN
        out_data <= ff_mix(tf_data, tap_pay.data, tap_pay.bypass);
`else
        out_data <= ff_mix(tf_data, tap_pay.data);
`endif
        out_tag  <= tap_pay.tag;
      end
    end
  end

  // Stage boundary: occupancy, flush guard and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= '0;
      guard_cnt <= '0;
      align_err <= 1'b0;
    end else if (flush) begin
      inflight  <= '0;
      guard_cnt <= CNT_W'(DEPTH);
      align_err <= 1'b0;
    end else begin
      if (accept && !dvalid) begin
        inflight <= inflight + CNT_W'(1);
      end else if (!accept && dvalid) begin
        inflight <= inflight - CNT_W'(1);
      end
      if (guard_on) begin
        guard_cnt <= guard_cnt - CNT_W'(1);
      end
      if (err_set) begin
        align_err <= 1'b1;
      end
    end
  end

  assign busy = (inflight != '0);

endmodule
